// File: rtl/cla_addsub_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | cla_addsub_pipe                                                          |
// | Pipelined 4-bit-group carry-lookahead adder/subtractor with flags.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cla_addsub_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int NGRP = WIDTH / 4;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
            $error("cla_addsub_pipe: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    // Result packing: [5] group carry-out, [4] carry into group MSB, [3:0] sum.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = x | y;
        g    = x & y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], c[3], x ^ y ^ c[3:0]};
    endfunction

    logic             r_vld_q [NGRP];
    logic [WIDTH-1:0] r_a_q   [NGRP];
    logic [WIDTH-1:0] r_b_q   [NGRP];
    logic [WIDTH-1:0] r_s_q   [NGRP];
    logic             r_c_q   [NGRP];
    logic             r_sat_q [NGRP];
    logic             r_ovf_q;
    logic             r_zero_q;

    logic             w_vld_in [NGRP];
    logic [WIDTH-1:0] w_a_in   [NGRP];
    logic [WIDTH-1:0] w_b_in   [NGRP];
    logic [WIDTH-1:0] w_s_in   [NGRP];
    logic             w_c_in   [NGRP];
    logic             w_sat_in [NGRP];
    logic [5:0]       w_grp    [NGRP];

    logic             w_vld_d [NGRP];
    logic [WIDTH-1:0] w_a_d   [NGRP];
    logic [WIDTH-1:0] w_b_d   [NGRP];
    logic [WIDTH-1:0] w_s_d   [NGRP];
    logic             w_c_d   [NGRP];
    logic             w_sat_d [NGRP];
    logic             w_ovf_d;
    logic             w_zero_d;
    logic             w_stall;

    assign w_stall  = r_vld_q[NGRP-1] & ~out_ready;
    assign in_ready = ~w_stall & rst;

    // Stage inputs: stage 0 takes the prepared operands, later stages the skew registers.
    always_comb begin
        w_vld_in[0] = in_valid & in_ready;
        w_a_in[0]   = a;
        w_b_in[0]   = sub ? ~b : b;
        w_c_in[0]   = sub ? ~cin : cin;
        w_sat_in[0] = sat;
        w_s_in[0]   = '0;
        for (int k = 1; k < NGRP; k++) begin
            w_vld_in[k] = r_vld_q[k-1];
            w_a_in[k]   = r_a_q[k-1];
            w_b_in[k]   = r_b_q[k-1];
            w_c_in[k]   = r_c_q[k-1];
            w_sat_in[k] = r_sat_q[k-1];
            w_s_in[k]   = r_s_q[k-1];
        end
    end

    always_comb begin
        w_ovf_d  = 1'b0;
        w_zero_d = 1'b0;
        for (int k = 0; k < NGRP; k++) begin
            w_grp[k]   = cla4(w_a_in[k][4*k +: 4], w_b_in[k][4*k +: 4], w_c_in[k]);
            w_vld_d[k] = w_vld_in[k];
            w_a_d[k]   = w_a_in[k];
            w_b_d[k]   = w_b_in[k];
            w_sat_d[k] = w_sat_in[k];
            w_c_d[k]   = w_grp[k][5];
            w_s_d[k]   = w_s_in[k];
            w_s_d[k][4*k +: 4] = w_grp[k][3:0];
        end
        // Last stage: overflow from MSB carries, clamp toward the sign of a.
        w_ovf_d = w_grp[NGRP-1][5] ^ w_grp[NGRP-1][4];
        if (w_sat_in[NGRP-1] && w_ovf_d) begin
            w_s_d[NGRP-1] = {w_a_in[NGRP-1][WIDTH-1], {(WIDTH-1){~w_a_in[NGRP-1][WIDTH-1]}}};
        end
        w_zero_d = (w_s_d[NGRP-1] == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NGRP; k++) begin
                r_vld_q[k] <= 1'b0;
                r_a_q[k]   <= '0;
                r_b_q[k]   <= '0;
                r_s_q[k]   <= '0;
                r_c_q[k]   <= 1'b0;
                r_sat_q[k] <= 1'b0;
            end
            r_ovf_q  <= 1'b0;
            r_zero_q <= 1'b0;
        end else if (!w_stall) begin
            for (int k = 0; k < NGRP; k++) begin
                r_vld_q[k] <= w_vld_d[k];
                r_a_q[k]   <= w_a_d[k];
                r_b_q[k]   <= w_b_d[k];
                r_s_q[k]   <= w_s_d[k];
                r_c_q[k]   <= w_c_d[k];
                r_sat_q[k] <= w_sat_d[k];
            end
            r_ovf_q  <= w_ovf_d;
            r_zero_q <= w_zero_d;
        end
    end

    assign out_valid = r_vld_q[NGRP-1];
    assign sum       = r_s_q[NGRP-1];
    assign cout      = r_c_q[NGRP-1];
    assign overflow  = r_ovf_q;
    assign zero      = r_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_addsub_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cla_addsub_pipe                                                       |
// | Directed and randomized checks of cla_addsub_pipe at WIDTH 4/16/32.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cla_addsub_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        d16_in_valid = 1'b0, d16_in_ready, d16_cin = 1'b0, d16_sub = 1'b0, d16_sat = 1'b0;
    logic        d16_out_valid, d16_out_ready = 1'b1, d16_cout, d16_overflow, d16_zero;
    logic [15:0] d16_a = '0, d16_b = '0, d16_sum;
    logic        d4_in_valid = 1'b0, d4_in_ready, d4_cin = 1'b0, d4_sub = 1'b0, d4_sat = 1'b0;
    logic        d4_out_valid, d4_out_ready = 1'b1, d4_cout, d4_overflow, d4_zero;
    logic [3:0]  d4_a = '0, d4_b = '0, d4_sum;
    logic        d32_in_valid = 1'b0, d32_in_ready, d32_cin = 1'b0, d32_sub = 1'b0, d32_sat = 1'b0;
    logic        d32_out_valid, d32_out_ready = 1'b1, d32_cout, d32_overflow, d32_zero;
    logic [31:0] d32_a = '0, d32_b = '0, d32_sum;

    cla_addsub_pipe #(.WIDTH(16)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(d16_in_valid), .in_ready(d16_in_ready),
        .a(d16_a), .b(d16_b), .cin(d16_cin), .sub(d16_sub), .sat(d16_sat),
        .out_valid(d16_out_valid), .out_ready(d16_out_ready), .sum(d16_sum),
        .cout(d16_cout), .overflow(d16_overflow), .zero(d16_zero));

    cla_addsub_pipe #(.WIDTH(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
        .a(d4_a), .b(d4_b), .cin(d4_cin), .sub(d4_sub), .sat(d4_sat),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready), .sum(d4_sum),
        .cout(d4_cout), .overflow(d4_overflow), .zero(d4_zero));

    cla_addsub_pipe #(.WIDTH(32)) u_d32 (
        .clk(clk), .rst(rst), .in_valid(d32_in_valid), .in_ready(d32_in_ready),
        .a(d32_a), .b(d32_b), .cin(d32_cin), .sub(d32_sub), .sat(d32_sat),
        .out_valid(d32_out_valid), .out_ready(d32_out_ready), .sum(d32_sum),
        .cout(d32_cout), .overflow(d32_overflow), .zero(d32_zero));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Packed result: {zero, overflow, cout, sum zero-extended to 32 bits}.
    function automatic logic [34:0] pk(input logic z, input logic o, input logic c,
                                       input logic [31:0] s);
        return {z, o, c, s};
    endfunction

    function automatic logic [34:0] obs16();
        return {d16_zero, d16_overflow, d16_cout, 16'd0, d16_sum};
    endfunction

    function automatic logic [34:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s, input logic st);
        logic [32:0] mask;
        logic [32:0] r;
        logic [31:0] ye;
        logic [31:0] res;
        logic        c0, ovf, sa, sb;
        mask = (33'd1 << w) - 33'd1;
        ye   = (s ? ~y : y) & mask[31:0];
        c0   = s ? ~ci : ci;
        r    = {1'b0, x & mask[31:0]} + {1'b0, ye} + {32'd0, c0};
        res  = r[31:0] & mask[31:0];
        sa   = x[w-1];
        sb   = ye[w-1];
        ovf  = (sa == sb) && (res[w-1] != sa);
        if (st && ovf) res = sa ? (32'd1 << (w - 1)) : (mask[31:0] >> 1);
        return {res == 32'd0, ovf, r[w], res};
    endfunction

    task automatic run16(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic s, input logic st, input logic [34:0] exp);
        int lat;
        int w;
        @(negedge clk);
        d16_a = x; d16_b = y; d16_cin = ci; d16_sub = s; d16_sat = st;
        d16_in_valid = 1'b1; d16_out_ready = 1'b1;
        #1;
        w = 0;
        while (!d16_in_ready && w < 20) begin @(negedge clk); #1; w++; end
        chk({tag, "_in_ready"}, 64'(d16_in_ready), 64'd1);
        @(posedge clk); #1;
        d16_in_valid = 1'b0;
        lat = 1;
        while (!d16_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        chk(tag, 64'(obs16()), 64'(exp));
        @(posedge clk); #1;
    endtask

    logic [15:0] bx [6];
    logic [15:0] by [6];
    logic        bc [6], bs [6], bt [6];
    logic [34:0] bexp [6];
    logic [34:0] q4 [$];
    logic [34:0] q32 [$];
    logic [34:0] e;
    int          sent, got, hold, seen, cyc, extra;
    logic        acc4 = 1'b0, acc32 = 1'b0;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(d16_out_valid), 64'd0);
        chk("rst_in_ready", 64'(d16_in_ready), 64'd0);
        chk("rst_outputs", 64'(obs16()), 64'(pk(0, 0, 0, 32'h0)));
        chk("rst_d4_out_valid", 64'(d4_out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_in_ready", 64'(d16_in_ready), 64'd1);

        // Directed WIDTH=16 vectors
        run16("add_basic", 16'h1234, 16'h0FFF, 0, 0, 0, pk(0, 0, 0, 32'h2233));
        run16("add_ovf",   16'h7FFF, 16'h0001, 0, 0, 0, pk(0, 1, 0, 32'h8000));
        run16("add_satmax", 16'h7FFF, 16'h0001, 0, 0, 1, pk(0, 1, 0, 32'h7FFF));
        run16("add_satmin", 16'h8000, 16'hFFFF, 0, 0, 1, pk(0, 1, 1, 32'h8000));
        run16("sub_neg",   16'h0005, 16'h0007, 0, 1, 0, pk(0, 0, 0, 32'hFFFE));
        run16("sub_zero",  16'h1234, 16'h1234, 0, 1, 0, pk(1, 0, 1, 32'h0000));
        run16("sub_borrow", 16'h0010, 16'h0001, 1, 1, 0, pk(0, 0, 1, 32'h000E));
        run16("sub_satmin", 16'h8000, 16'h0001, 0, 1, 1, pk(0, 1, 1, 32'h8000));
        run16("add_wrap0", 16'hFFFF, 16'h0001, 0, 0, 1, pk(1, 0, 1, 32'h0000));

        // WIDTH=4 single beat, one-cycle latency
        @(negedge clk);
        d4_a = 4'hF; d4_b = 4'h1; d4_cin = 1'b1; d4_sub = 1'b0; d4_sat = 1'b0; d4_in_valid = 1'b1;
        @(posedge clk); #1;
        d4_in_valid = 1'b0;
        chk("w4_latency", 64'(d4_out_valid), 64'd1);
        chk("w4_result", 64'({d4_zero, d4_overflow, d4_cout, 28'd0, d4_sum}),
            64'(pk(0, 0, 1, 32'h1)));
        @(posedge clk); #1;

        // Backpressure: six back-to-back beats, three-cycle stall on the first result
        for (int i = 0; i < 6; i++) begin
            bx[i] = 16'($urandom); by[i] = 16'($urandom);
            bc[i] = 1'($urandom); bs[i] = 1'($urandom); bt[i] = 1'($urandom);
            bexp[i] = model(16, {16'd0, bx[i]}, {16'd0, by[i]}, bc[i], bs[i], bt[i]);
        end
        sent = 0; got = 0; hold = 0; seen = 0; cyc = 0;
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            d16_in_valid = (sent < 6);
            if (sent < 6) begin
                d16_a = bx[sent]; d16_b = by[sent]; d16_cin = bc[sent];
                d16_sub = bs[sent]; d16_sat = bt[sent];
            end
            if (d16_out_valid && seen == 0) begin seen = 1; hold = 3; end
            d16_out_ready = (hold == 0);
            #1;
            if (hold > 0) begin
                chk("bp_in_ready", 64'(d16_in_ready), 64'd0);
                chk("bp_hold_valid", 64'(d16_out_valid), 64'd1);
                chk("bp_hold_data", 64'(obs16()), 64'(bexp[got]));
                hold--;
            end else if (d16_out_valid) begin
                chk($sformatf("bp_beat%0d", got), 64'(obs16()), 64'(bexp[got]));
                got++;
            end
            if (d16_in_valid && d16_in_ready) sent++;
        end
        chk("bp_count", 64'(got), 64'd6);
        @(negedge clk);
        d16_in_valid = 1'b0; d16_out_ready = 1'b1;
        extra = 0;
        repeat (6) begin @(posedge clk); #1; if (d16_out_valid) extra++; end
        chk("bp_no_dup", 64'(extra), 64'd0);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d16_in_valid = 1'b1; d16_a = 16'h1111 * 16'(i + 1); d16_b = 16'h0101;
            d16_cin = 1'b0; d16_sub = 1'b0; d16_sat = 1'b0;
        end
        @(negedge clk);
        d16_in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 64'(d16_out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(d16_in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        extra = 0;
        repeat (8) begin @(posedge clk); #1; if (d16_out_valid) extra++; end
        chk("mid_rst_flushed", 64'(extra), 64'd0);
        run16("post_rst", 16'h00FF, 16'h0F01, 0, 0, 0, pk(0, 0, 0, 32'h1000));

        // Random streams on WIDTH=4 and WIDTH=32 with random out_ready
        for (int c = 0; c < 330; c++) begin
            @(negedge clk);
            if (acc4 || !d4_in_valid) begin
                d4_a = 4'($urandom); d4_b = 4'($urandom); d4_cin = 1'($urandom);
                d4_sub = 1'($urandom); d4_sat = 1'($urandom);
                d4_in_valid = ($urandom_range(0, 3) != 0) && (c < 280);
            end
            if (acc32 || !d32_in_valid) begin
                d32_a = $urandom; d32_b = $urandom; d32_cin = 1'($urandom);
                d32_sub = 1'($urandom); d32_sat = 1'($urandom);
                if ($urandom_range(0, 3) == 0) d32_b = 32'h7FFF_FFFF;
                d32_in_valid = ($urandom_range(0, 3) != 0) && (c < 280);
            end
            d4_out_ready  = (c >= 300) || ($urandom_range(0, 3) != 0);
            d32_out_ready = (c >= 300) || ($urandom_range(0, 2) != 0);
            #1;
            if (d4_out_valid && d4_out_ready) begin
                chk("r4_expected_beat", 64'(q4.size() != 0), 64'd1);
                if (q4.size() != 0) begin
                    e = q4.pop_front();
                    chk("r4_beat", 64'({d4_zero, d4_overflow, d4_cout, 28'd0, d4_sum}), 64'(e));
                end
            end
            if (d32_out_valid && d32_out_ready) begin
                chk("r32_expected_beat", 64'(q32.size() != 0), 64'd1);
                if (q32.size() != 0) begin
                    e = q32.pop_front();
                    chk("r32_beat", 64'({d32_zero, d32_overflow, d32_cout, d32_sum}), 64'(e));
                end
            end
            acc4 = d4_in_valid && d4_in_ready;
            if (acc4) q4.push_back(model(4, {28'd0, d4_a}, {28'd0, d4_b}, d4_cin, d4_sub, d4_sat));
            acc32 = d32_in_valid && d32_in_ready;
            if (acc32) q32.push_back(model(32, d32_a, d32_b, d32_cin, d32_sub, d32_sat));
        end
        chk("r4_drained", 64'(q4.size()), 64'd0);
        chk("r32_drained", 64'(q32.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor for the NPC datapath. It processes one 4-bit lookahead group per pipeline stage, and the group carry passes from stage to stage. It accepts one operation per cycle through a valid/ready handshake. Outputs are sum, carry-out, signed overflow and zero flags, with optional signed saturation.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4 (elaborate-time error otherwise)
NGRP, WIDTH/4, derived; number of 4-bit groups, equal to the number of pipeline stages and the latency in cycles

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low
in_valid  in  1  operand beat present
in_ready  out  1  block can accept a beat this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in when adding; borrow-in when subtracting
sub  in  1  1 = subtract (a - b - cin), 0 = add (a + b + cin)
sat  in  1  1 = saturate the result on signed overflow
out_valid  out  1  result beat present
out_ready  in  1  downstream accepts result
sum  out  WIDTH  result
cout  out  1  carry out of MSB; for subtract, 1 = no borrow
overflow  out  1  signed overflow of the unsaturated result
zero  out  1  final (post-saturation) sum == 0

Behaviour:
- Reset (rst low at a clk edge): clear all stage valid bits, out_valid, sum, cout, overflow, zero and all pipeline data registers to 0. Any in-flight beats are discarded and never emerge. in_ready = 0 while rst is low.
- Operand prep at the input boundary: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin.
- Stage k (0..NGRP-1) handles group k:
  - p = a_eff | b_eff and g = a_eff & b_eff on bits [4k+3:4k].
  - The four internal carries use full lookahead equations (no ripple) from the group carry-in.
  - Per-bit sum = a ^ b_eff ^ carry.
  - The group carry-out is registered into stage k+1.
  - Upper-group operand bits travel in skew registers; completed lower sum bits travel in deskew registers, so all WIDTH result bits emerge together.
- Latency: exactly NGRP cycles from the accepting edge (in_valid & in_ready) to out_valid = 1, when there are no stalls. Throughput is 1 beat per cycle.
- Flags, computed in the last stage:
  - cout = carry out of bit WIDTH-1.
  - overflow = carry into MSB XOR carry out of MSB.
- Saturation applies when sat = 1 and overflow = 1:
  - sum = 0 followed by all ones (signed max) if the sign of a is 0.
  - Otherwise sum = 1 followed by all zeros (signed min).
  - overflow still reads 1 and cout is unchanged.
  - The sat bit travels through the pipeline with its beat.
- zero is evaluated on the final sum after saturation.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall & rst.
  - On stall, every stage (valid and data) holds its value. sum, cout, overflow, zero and out_valid stay stable until the beat is accepted.
  - Bubbles are not compacted; the pipeline advances or holds as one unit.
  - in_ready depends combinationally on out_ready; this is permitted.
  - A beat offered while in_ready = 0 is not captured. The source must hold it.
  - Stage valid bits only advance when the pipeline is not stalled.
- Simultaneous output accept and input accept in the same cycle is allowed: the pipeline shifts and the new beat enters stage 0.
- Beat order is preserved. No beat is lost or duplicated.
- sum and the flags are don't-care while out_valid = 0, but must not change while a stalled valid beat is held.

Test Plan:
- WIDTH=16: a=0x1234, b=0x0FFF, cin=0, sub=0, sat=0 -> sum=0x2233, cout=0, overflow=0, zero=0; out_valid exactly 4 cycles after the accept edge.
- WIDTH=16: a=0x7FFF, b=0x0001, add, sat=0 -> sum=0x8000, overflow=1, cout=0. The same operands with sat=1 -> sum=0x7FFF, overflow=1. a=0x8000, b=0xFFFF, add, sat=1 -> sum=0x8000, overflow=1, cout=1.
- WIDTH=16, subtract: a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0, overflow=0. a=b=0x1234, sub=1 -> sum=0x0000, zero=1, cout=1.
- Backpressure: stream 6 back-to-back random beats and hold out_ready=0 for 3 cycles once the first result appears -> in_ready=0 in those same cycles, outputs stable, all 6 results correct and in order, no duplicates.
- Reset mid-stream: with 3 beats in flight, drive rst=0 for one edge -> out_valid=0 after that edge, and none of the 3 beats ever appears. New beats after release complete with normal latency.
- WIDTH=4: a=0xF, b=0x1, cin=1, add -> sum=0x1, cout=1, overflow=0, latency 1 cycle. Also a full random compare against a reference model for WIDTH=4, 16 and 32 with random out_ready.
